// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an RS-232 transmitter over its start/busy handshake.
// Queued bytes are launched one at a time as soon as the transmitter is free.
module uart_tx_fifo #(
  parameter  int DEPTH        = 16,
  parameter  int BUSY_TIMEOUT = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_err,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   timer_inc;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            overflow_q, overflow_d;
  logic            tx_err_q, tx_err_d;
  logic            push, pop;
  logic [7:0]      mem_q [DEPTH];

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_err   = tx_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  assign push      = wr_en & ~full & ~flush;
  assign pop       = (state_q == IDLE) & ~empty & ~tx_busy & ~flush;
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = wr_en & full & ~flush;
    tx_start_d = pop;
    tx_data_d  = tx_data_q;
    tx_err_d   = 1'b0;
    timer_d    = timer_q;
    state_d    = state_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
    end
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
        timer_d = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_inc == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged: drop the byte, no retry.
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model.
// A simple transmitter model answers tx_start with a busy window.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int BT    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full, empty, overflow, tx_err, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_err   (tx_err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [7:0] q[$];
  bit         act, seen;
  int         age;
  bit         e_start, e_ovf, e_err;
  logic [7:0] e_data;

  // transmitter model
  int  tx_rem, hold;
  bit  force_busy, mute, rnd_mode;

  // observation
  int         cyc;
  int         nstart;
  int         err_cyc;
  logic [7:0] sent[$];
  int         start_cycs[$];

  function automatic void model_reset();
    q.delete();
    act = 0; seen = 0; age = 0;
    e_start = 0; e_ovf = 0; e_err = 0; e_data = '0;
  endfunction

  function automatic void model_edge(bit we, logic [7:0] d, bit fl, bit b);
    bit fullp, pop;
    fullp = (q.size() == DEPTH);
    pop   = !act && q.size() != 0 && !b && !fl;
    e_ovf = we && fullp && !fl;
    e_err = 0;
    e_start = pop;
    if (pop) begin
      e_data = q[0];
      act = 1; age = 0; seen = 0;
    end else if (act) begin
      if (age == 0) age = 1;
      else if (!seen) begin
        if (b) seen = 1;
        else if (age == BT - 1) begin
          e_err = 1;
          act = 0;
        end else age++;
      end else if (!b) act = 0;
    end
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (we && !fullp) q.push_back(d);
    end
  endfunction

  function automatic void tx_update();
    bit skip;
    skip = mute;
    if (e_start) begin
      if (rnd_mode) begin
        hold = $urandom_range(1, 12);
        skip = ($urandom_range(0, 9) == 0);
      end
      if (!skip) tx_rem = hold;
    end
    tx_busy = force_busy || tx_rem > 0;
    if (tx_rem > 0) tx_rem--;
  endfunction

  task automatic observe();
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("ovf", overflow, e_ovf);
    chk("err", tx_err, e_err);
    chk("start", tx_start, e_start);
    chk("data", tx_data, e_data);
    chk("start_busy", tx_start & tx_busy, 0);
    if (tx_start) begin
      sent.push_back(tx_data);
      start_cycs.push_back(cyc);
      nstart++;
    end
    if (tx_err && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic step(input bit we, input logic [7:0] d, input bit fl);
    wr_en = we; wr_data = d; flush = fl;
    @(posedge clk);
    cyc++;
    model_edge(we, d, fl, tx_busy);
    @(negedge clk);
    observe();
    tx_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12 && !(act && seen); i++) idle(1);
  endtask

  initial begin
    int w, base, n;
    rst_n = 0; wr_en = 0; wr_data = 0; flush = 0; tx_busy = 0;
    tx_rem = 0; hold = 10; force_busy = 0; mute = 0; rnd_mode = 0;
    cyc = 0; nstart = 0; err_cyc = -1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", tx_err, 0);
    rst_n = 1;

    // 1: single byte latency
    step(1, 8'h55, 0);
    w = cyc;
    idle(20);
    chk("t1_nstart", nstart, 1);
    chk("t1_lat", start_cycs.size() > 0 ? start_cycs[0] - w : -1, 1);
    chk("t1_data", sent.size() > 0 ? sent[0] : 8'hxx, 8'h55);

    // 2: fill, overflow, drain in order
    force_busy = 1; tx_busy = 1; hold = 3;
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0);
    chk("t2_full", full, 1);
    chk("t2_cnt", count, 16);
    step(1, 8'hAA, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_cnt2", count, 16);
    force_busy = 0; tx_busy = 0;
    sent.delete();
    idle(150);
    chk("t2_n", sent.size(), 16);
    for (int i = 0; i < sent.size() && i < 16; i++)
      chk("t2_seq", sent[i], 8'(i + 1));

    // 3: steady count=8 with simultaneous push/pop and wrap
    force_busy = 1; tx_busy = 1;
    for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0);
    force_busy = 0; tx_busy = 0;
    sent.delete();
    n = 8;
    for (int i = 0; i < 80; i++) begin
      if (!act && q.size() != 0 && !tx_busy) begin
        step(1, 8'(8'h30 + n), 0);
        n++;
      end else idle(1);
    end
    chk("t3_cnt", count, 8);
    chk("t3_many", sent.size() >= 10, 1);
    for (int i = 0; i < sent.size(); i++)
      chk("t3_seq", sent[i], 8'(8'h30 + i));
    idle(100);

    // 4: transmitter never answers
    force_busy = 1; tx_busy = 1;
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    force_busy = 0; tx_busy = 0; mute = 1;
    sent.delete(); start_cycs.delete(); err_cyc = -1;
    idle(20);
    chk("t4_n", sent.size(), 2);
    chk("t4_d0", sent.size() > 0 ? sent[0] : 8'hxx, 8'hA1);
    chk("t4_d1", sent.size() > 1 ? sent[1] : 8'hxx, 8'hA2);
    chk("t4_lat", start_cycs.size() > 0 ? err_cyc - start_cycs[0] : -1, 4);
    mute = 0;

    // 5: flush while a byte is in flight
    hold = 30;
    step(1, 8'h11, 0);
    wait_done();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
    base = nstart;
    step(1, 8'h77, 1);
    chk("t5_cnt", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ovf", overflow, 0);
    idle(40);
    chk("t5_nstart", nstart - base, 0);

    // 6: async reset mid-transmission
    step(1, 8'h21, 0);
    wait_done();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0);
    #2 rst_n = 0;
    #1;
    chk("t6_cnt", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_start", tx_start, 0);
    chk("t6_data", tx_data, 0);
    model_reset();
    @(negedge clk);
    tx_update();
    rst_n = 1;
    base = nstart;
    chk("t6_busy", tx_busy, 1);
    for (int i = 0; i < 40 && tx_busy; i++) idle(1);
    chk("t6_nstart", nstart - base, 0);
    step(1, 8'h5A, 0);
    idle(6);
    chk("t6_resume", sent.size() > 0 ? sent[sent.size()-1] : 8'hxx, 8'h5A);

    // random traffic
    rnd_mode = 1;
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 31) == 0);
    rnd_mode = 0; hold = 3;
    idle(100);
    chk("final_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
